// File: rtl/d7_output_sequencer.sv
// d7_output_sequencer: accepts a binary value from the CPU output port and
// converts it to packed BCD with a serial double-dabble engine, one iteration
// per clock. It then presents the digits with bcd_valid high for HOLD_CYCLES.
module d7_output_sequencer #(
  parameter int WIDTH       = 32,
  parameter int DIGITS      = 8,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                out_req,
  input  logic [WIDTH-1:0]    out_value,
  output logic                out_ack,
  output logic                busy,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                bcd_valid,
  output logic                overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int IW = $clog2(WIDTH + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  // Largest value that fits in DIGITS decimal digits (10^DIGITS - 1).
  function automatic logic [63:0] max_bcd_value();
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < DIGITS; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VALUE = max_bcd_value();
  localparam logic [IW-1:0] LAST_ITER = IW'(WIDTH - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  // One double-dabble iteration: add 3 to each BCD nibble >= 5, then shift left.
  function automatic logic [SW-1:0] dabble_step(input logic [SW-1:0] v);
    logic [SW-1:0] t;
    t = v;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (t[WIDTH + 4*d +: 4] >= 4'd5)
        t[WIDTH + 4*d +: 4] = t[WIDTH + 4*d +: 4] + 4'd3;
    end
    return {t[SW-2:0], 1'b0};
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   sr, sr_nxt, sr_step;
  logic [IW-1:0]   iter, iter_nxt;
  logic [HW-1:0]   hold, hold_nxt;
  logic            ovf_pend, ovf_pend_nxt;
  logic [BW-1:0]   bcd_out_nxt;
  logic            bcd_valid_nxt, out_ack_nxt, busy_nxt, overflow_nxt;
  logic            accept;

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      iter      <= '0;
      hold      <= '0;
      ovf_pend  <= 1'b0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      out_ack   <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      iter      <= iter_nxt;
      hold      <= hold_nxt;
      ovf_pend  <= ovf_pend_nxt;
      bcd_out   <= bcd_out_nxt;
      bcd_valid <= bcd_valid_nxt;
      out_ack   <= out_ack_nxt;
      busy      <= busy_nxt;
      overflow  <= overflow_nxt;
    end
  end

  // Next-state logic: conversion steps, hold countdown, and request acceptance.
  always_comb begin
    state_nxt     = state;
    sr_nxt        = sr;
    iter_nxt      = iter;
    hold_nxt      = hold;
    ovf_pend_nxt  = ovf_pend;
    bcd_out_nxt   = bcd_out;
    bcd_valid_nxt = bcd_valid;
    out_ack_nxt   = 1'b0;
    busy_nxt      = busy;
    overflow_nxt  = overflow;
    sr_step       = dabble_step(sr);
    accept        = out_req && (state == IDLE || state == SHOW);

    case (state)
      CONV: begin
        sr_nxt   = sr_step;
        iter_nxt = iter + 1'b1;
        if (iter == LAST_ITER) begin
          bcd_out_nxt   = ovf_pend ? '1 : sr_step[SW-1 -: BW];
          overflow_nxt  = ovf_pend;
          bcd_valid_nxt = 1'b1;
          busy_nxt      = 1'b0;
          hold_nxt      = HOLD_LAST;
          state_nxt     = SHOW;
        end
      end
      SHOW: begin
        if (hold == '0) begin
          bcd_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end else begin
          hold_nxt = hold - 1'b1;
        end
      end
      default: ;
    endcase

    // A request in IDLE or SHOW overrides the state-specific updates above.
    if (accept) begin
      sr_nxt        = {{BW{1'b0}}, out_value};
      iter_nxt      = '0;
      ovf_pend_nxt  = 64'(out_value) > MAX_VALUE;
      out_ack_nxt   = 1'b1;
      busy_nxt      = 1'b1;
      bcd_valid_nxt = 1'b0;
      state_nxt     = CONV;
    end
  end

endmodule

// File: tb/tb_d7_output_sequencer.sv
// Directed bench for d7_output_sequencer at default parameters.
module tb_d7_output_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        out_req = 1'b0;
  logic [31:0] out_value = '0;
  logic        out_ack, busy, bcd_valid, overflow;
  logic [31:0] bcd_out;

  int nvec = 0;
  int nerr = 0;

  d7_output_sequencer #(.WIDTH(32), .DIGITS(8), .HOLD_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .out_req(out_req), .out_value(out_value),
    .out_ack(out_ack), .busy(busy), .bcd_out(bcd_out),
    .bcd_valid(bcd_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Stimulus helper: request v, wait for ack, then for bcd_valid (both bounded).
  // Called at #1 after a rising edge; returns at #1 after the edge bcd_valid rose.
  task automatic convert(input logic [31:0] v, output int ack_lat, output int conv_lat,
                         output bit held, output bit busy_ok);
    logic [31:0] old;
    old = bcd_out; held = 1'b1; busy_ok = 1'b1;
    out_value = v; out_req = 1'b1; ack_lat = -1; conv_lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (out_ack) begin ack_lat = i; break; end
    end
    out_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bcd_valid) begin conv_lat = i + 1; break; end
      if (bcd_out !== old) held = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    nvec++; if (bcd_out !== 32'h0) begin nerr++; $display("FAIL reset_bcd_out: got %h want %h", bcd_out, 32'h0); end
    nvec++; if (bcd_valid !== 1'b0) begin nerr++; $display("FAIL reset_bcd_valid: got %b want 0", bcd_valid); end
    nvec++; if (out_ack !== 1'b0) begin nerr++; $display("FAIL reset_out_ack: got %b want 0", out_ack); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
    nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_convert();
    int al, cl, n; bit held, bok;
    convert(32'd12_345_678, al, cl, held, bok);
    nvec++; if (al !== 0) begin nerr++; $display("FAIL conv_ack_latency: got %0d want 0", al); end
    nvec++; if (cl !== 32) begin nerr++; $display("FAIL conv_latency: got %0d want 32", cl); end
    nvec++; if (bcd_out !== 32'h1234_5678) begin nerr++; $display("FAIL conv_bcd: got %h want 12345678", bcd_out); end
    nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL conv_overflow: got %b want 0", overflow); end
    nvec++; if (held !== 1'b1) begin nerr++; $display("FAIL conv_old_digits_held: got %b want 1", held); end
    nvec++; if (bok !== 1'b1 || busy !== 1'b0) begin nerr++; $display("FAIL conv_busy: got ok=%b end=%b want 1/0", bok, busy); end
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bcd_valid) n++; else break;
    end
    nvec++; if (n !== 16) begin nerr++; $display("FAIL hold_cycles: got %0d want 16", n); end
  endtask

  task automatic test_hold_expiry();
    int al, cl; bit held, bok;
    nvec++; if (bcd_valid !== 1'b0) begin nerr++; $display("FAIL expiry_valid: got %b want 0", bcd_valid); end
    nvec++; if (bcd_out !== 32'h1234_5678) begin nerr++; $display("FAIL expiry_bcd_kept: got %h want 12345678", bcd_out); end
    repeat (3) @(posedge clk); #1;
    nvec++; if (bcd_valid !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL expiry_quiet: got valid=%b busy=%b want 0/0", bcd_valid, busy); end
    convert(32'd0, al, cl, held, bok);
    nvec++; if (al !== 0 || cl !== 32) begin nerr++; $display("FAIL idle_accept: got ack=%0d conv=%0d want 0/32", al, cl); end
  endtask

  task automatic test_bounds();
    int al, cl; bit held, bok;
    nvec++; if (bcd_out !== 32'h0) begin nerr++; $display("FAIL bound_zero: got %h want 00000000", bcd_out); end
    convert(32'd99_999_999, al, cl, held, bok);
    nvec++; if (al !== 0) begin nerr++; $display("FAIL bound_show_accept: got %0d want 0", al); end
    nvec++; if (bcd_out !== 32'h9999_9999) begin nerr++; $display("FAIL bound_max: got %h want 99999999", bcd_out); end
    nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL bound_max_ovf: got %b want 0", overflow); end
    convert(32'd100_000_000, al, cl, held, bok);
    nvec++; if (bcd_out !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL bound_over: got %h want ffffffff", bcd_out); end
    nvec++; if (overflow !== 1'b1) begin nerr++; $display("FAIL bound_over_ovf: got %b want 1", overflow); end
    convert(32'd4_294_967_295, al, cl, held, bok);
    nvec++; if (bcd_out !== 32'hFFFF_FFFF || overflow !== 1'b1) begin nerr++; $display("FAIL bound_allones: got %h/%b want ffffffff/1", bcd_out, overflow); end
    convert(32'd90_817_263, al, cl, held, bok);
    nvec++; if (bcd_out !== 32'h9081_7263 || overflow !== 1'b0) begin nerr++; $display("FAIL mixed_digits: got %h/%b want 90817263/0", bcd_out, overflow); end
  endtask

  task automatic test_busy();
    int extra, got;
    out_value = 32'd9; out_req = 1'b1; got = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_ack) begin got = 1; break; end
    end
    out_req = 1'b0;
    nvec++; if (got !== 1) begin nerr++; $display("FAIL busy_first_ack: got %0d want 1", got); end
    repeat (5) @(posedge clk); #1;
    out_value = 32'd42; out_req = 1'b1; extra = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (out_ack) extra++;
      if (bcd_valid) break;
    end
    nvec++; if (extra !== 0) begin nerr++; $display("FAIL busy_no_ack_in_conv: got %0d acks want 0", extra); end
    nvec++; if (bcd_valid !== 1'b1 || bcd_out !== 32'h9) begin nerr++; $display("FAIL busy_first_result: got %b/%h want 1/00000009", bcd_valid, bcd_out); end
    @(posedge clk); #1;
    nvec++; if (out_ack !== 1'b1 || bcd_valid !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL busy_show_accept: got ack=%b valid=%b busy=%b want 1/0/1", out_ack, bcd_valid, busy); end
    out_req = 1'b0;
    @(posedge clk); #1;
    nvec++; if (out_ack !== 1'b0) begin nerr++; $display("FAIL busy_ack_pulse: got %b want 0", out_ack); end
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (bcd_valid) begin got = 1; break; end
    end
    nvec++; if (got !== 1 || bcd_out !== 32'h42) begin nerr++; $display("FAIL busy_second_result: got %0d/%h want 1/00000042", got, bcd_out); end
  endtask

  task automatic test_reset_mid_op();
    int al, cl, got; bit held, bok, quiet;
    out_value = 32'd777; out_req = 1'b1; got = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_ack) begin got = 1; break; end
    end
    out_req = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    nvec++; if (got !== 1 || bcd_out !== 32'h0 || busy !== 1'b0) begin nerr++; $display("FAIL midop_reset: got ack=%0d bcd=%h busy=%b want 1/00000000/0", got, bcd_out, busy); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bcd_valid !== 1'b0 || bcd_out !== 32'h0 || busy !== 1'b0) quiet = 1'b0;
    end
    nvec++; if (quiet !== 1'b1) begin nerr++; $display("FAIL midop_no_partial: got %b want 1", quiet); end
    convert(32'd5, al, cl, held, bok);
    nvec++; if (al !== 0 || cl !== 32) begin nerr++; $display("FAIL midop_relatency: got ack=%0d conv=%0d want 0/32", al, cl); end
    nvec++; if (bcd_out !== 32'h5 || overflow !== 1'b0) begin nerr++; $display("FAIL midop_result: got %h/%b want 00000005/0", bcd_out, overflow); end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_hold_expiry();
    test_bounds();
    test_busy();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
